// File: rtl/shift_pkg.sv
// Shared definitions for the iterative shift engine: direction codes,
// FSM state encoding and the default datapath width.
package shift_pkg;
  localparam int   WIDTH_DEF = 32;
  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;
endpackage

// File: rtl/shift_step.sv
// One increment of the iterative shifter: arithmetic right or logical left
// by k bits, where k never exceeds STEP.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int STEP  = 4,
  localparam int KW   = $clog2(STEP + 1)
) (
  input  logic             i_dir,
  input  logic [KW-1:0]    i_k,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);
  assign o_data = (i_dir == DIR_LEFT) ? (i_data << i_k)
                                      : $unsigned($signed(i_data) >>> i_k);
endmodule

// File: rtl/iter_shift_unit.sv
// Multi-cycle shift engine: accepts {dir, amt, data}, shifts at most STEP
// bits per clock, and holds the result until the consumer takes it.
module iter_shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int STEP  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_dir,
  input  logic [31:0]      in_amt,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);
  localparam int RW = $clog2(WIDTH + 1);
  localparam int KW = $clog2(STEP + 1);
  localparam logic [RW-1:0] W_SAT  = RW'(WIDTH);
  localparam logic [RW-1:0] STEP_R = RW'(STEP);

  state_e           r_state, w_next;
  logic             r_dir;
  logic [RW-1:0]    r_rem, w_amt;
  logic [KW-1:0]    w_k;
  logic [WIDTH-1:0] r_data, w_step;
  logic             w_accept;

  // Anything at or beyond WIDTH produces the same result as WIDTH.
  assign w_amt    = (in_amt >= 32'(WIDTH)) ? W_SAT : in_amt[RW-1:0];
  assign w_k      = (r_rem >= STEP_R) ? KW'(STEP) : r_rem[KW-1:0];
  assign w_accept = in_valid & in_ready;
  assign out_data = r_data;

  shift_step #(.WIDTH(WIDTH), .STEP(STEP)) u_step (
    .i_dir  (r_dir),
    .i_k    (w_k),
    .i_data (r_data),
    .o_data (w_step)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = (w_amt != '0) ? SHIFT : DONE;
      end
      SHIFT: begin
        busy = 1'b1;
        if (r_rem == RW'(w_k)) w_next = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dir  <= DIR_RIGHT;
      r_rem  <= '0;
      r_data <= '0;
    end else if (w_accept) begin
      r_dir  <= in_dir;
      r_rem  <= w_amt;
      r_data <= in_data;
    end else if (r_state == SHIFT) begin
      r_data <= w_step;
      r_rem  <= r_rem - RW'(w_k);
    end
  end
endmodule

// File: tb/tb_iter_shift_unit.sv
// Scoreboard bench for iter_shift_unit: directed requests push expected
// {data, latency}; a negedge monitor checks every presented result.
module tb_iter_shift_unit;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, in_dir, out_valid, out_ready, busy;
  logic [31:0] in_amt, in_data, out_data;

  typedef struct { logic [31:0] data; int lat; } exp_t;
  exp_t exp_q[$];
  int   acc_q[$];
  int   errors = 0, checks = 0, cyc = 0, last_hs = 0;
  bit   seen = 0;

  iter_shift_unit #(.WIDTH(32), .STEP(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_dir(in_dir), .in_amt(in_amt), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare on first sight of out_valid, retire on handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      acc_q.delete();
      seen = 0;
    end else begin
      if (out_valid && !seen) begin
        seen = 1;
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: got %h expected none", out_data);
        end else begin
          check("out_data", out_data, exp_q[0].data);
          check("latency", 32'(cyc - acc_q[0] + 1), 32'(exp_q[0].lat));
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() > 0) exp_q.delete(0);
        if (acc_q.size() > 0) acc_q.delete(0);
        seen    = 0;
        last_hs = cyc + 1;
      end
      if (in_valid && in_ready) acc_q.push_back(cyc + 1);
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge, in_valid still high.
  task automatic send(input logic dir, input logic [31:0] amt, input logic [31:0] data,
                      input logic [31:0] exp, input int lat, input bit push);
    exp_t e;
    int   n;
    bit   acc;
    if (push) begin e.data = exp; e.lat = lat; exp_q.push_back(e); end
    in_valid = 1'b1; in_dir = dir; in_amt = amt; in_data = data;
    n = 0; acc = 0;
    while (!acc && n < 200) begin @(negedge clk); acc = in_ready; n++; end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready got 0 expected 1");
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 300) begin @(negedge clk); n++; end
    if (exp_q.size() > 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: pending got %0d expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic txn(input logic dir, input logic [31:0] amt, input logic [31:0] data,
                     input logic [31:0] exp, input int lat);
    send(dir, amt, data, exp, lat, 1'b1);
    in_valid = 1'b0;
    wait_drain();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    exp_t e;
    rst_n = 0; in_valid = 0; in_dir = 0; in_amt = 0; in_data = 0; out_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;

    // Basic right/left shifts, exact and partial steps, saturation.
    txn(1'b0, 32'd1,  32'h8000_0000, 32'hC000_0000, 2);
    txn(1'b0, 32'd2,  32'h8000_0000, 32'hE000_0000, 2);
    txn(1'b1, 32'd9,  32'h0000_0001, 32'h0000_0200, 4);
    txn(1'b0, 32'd0,  32'h1234_5678, 32'h1234_5678, 1);
    txn(1'b0, 32'd40, 32'h8000_0001, 32'hFFFF_FFFF, 9);
    txn(1'b1, 32'd40, 32'h8000_0001, 32'h0000_0000, 9);
    txn(1'b0, 32'd40, 32'h7FFF_FFFF, 32'h0000_0000, 9);
    txn(1'b0, 32'd5,  32'hF000_0000, 32'hFF80_0000, 3);
    txn(1'b1, 32'd31, 32'h0000_0001, 32'h8000_0000, 9);
    txn(1'b0, 32'hFFFF_FFFF, 32'h4000_0000, 32'h0000_0000, 9);
    txn(1'b1, 32'd4,  32'h0000_000F, 32'h0000_00F0, 2);

    // Backpressure: result held, new request waits for the handshake.
    out_ready = 0;
    send(1'b1, 32'd8, 32'h0000_00FF, 32'h0000_FF00, 3, 1'b1);
    in_valid = 0;
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    e.data = 32'hF800_0000; e.lat = 2; exp_q.push_back(e);
    in_valid = 1; in_dir = 1'b0; in_amt = 32'd4; in_data = 32'h8000_0000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_data", out_data, 32'h0000_FF00);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!in_ready && n < 50);
    @(posedge clk); #1;
    in_valid = 0;
    wait_drain();

    // Reset during the third shift cycle aborts the operation.
    send(1'b0, 32'd31, 32'h8000_0001, 32'h0, 0, 1'b0);
    in_valid = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 0;
    @(posedge clk);
    @(negedge clk);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_out_data", out_data, 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    rst_n = 1;
    @(posedge clk); #1;
    txn(1'b0, 32'd12, 32'hF0F0_F0F0, 32'hFFFF_0F0F, 4);

    // Back-to-back with out_ready tied high.
    out_ready = 1;
    send(1'b1, 32'd3,  32'h0000_0003, 32'h0000_0018, 2, 1'b1);
    send(1'b0, 32'd16, 32'h7000_0000, 32'h0000_7000, 5, 1'b1);
    check("b2b_accept_edge", 32'(cyc), 32'(last_hs + 1));
    in_valid = 0;
    wait_drain();

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
